// File: rtl/tetris_input_pkg.sv
// Shared scan codes, action indices and repeat-timer states for the
// Tetris keyboard front end.
package tetris_input_pkg;

  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_UP     = 8'h75;
  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;

  localparam int unsigned NUM_ACT = 6;

  typedef enum logic [2:0] {
    ACT_LEFT  = 3'd0,
    ACT_RIGHT = 3'd1,
    ACT_DOWN  = 3'd2,
    ACT_ROT   = 3'd3,
    ACT_DROP  = 3'd4,
    ACT_HOLD  = 3'd5
  } action_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    AR_IDLE = 2'd0,
    AR_DAS  = 2'd1,
    AR_ARR  = 2'd2
  } ar_state_e;

  // One-hot action mask for a scan code; unmapped codes give zero.
  function automatic logic [NUM_ACT-1:0] key_mask(
    input logic [7:0] code
  );
    logic [NUM_ACT-1:0] m;
    m = '0;
    unique case (1'b1)
      (code == KEY_LEFT):   m[ACT_LEFT]  = 1'b1;
      (code == KEY_RIGHT):  m[ACT_RIGHT] = 1'b1;
      (code == KEY_DOWN):   m[ACT_DOWN]  = 1'b1;
      (code == KEY_UP):     m[ACT_ROT]   = 1'b1;
      (code == KEY_SPACE):  m[ACT_DROP]  = 1'b1;
      (code == KEY_LSHIFT): m[ACT_HOLD]  = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_auto_repeat.sv
// Press/held repeat timer: first fire FIRST cycles after press,
// then every PERIOD cycles while held.
module auto_repeat
  import tetris_input_pkg::*;
#(
  parameter int unsigned FIRST  = 16,
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic held,
  output logic fire
);

  localparam int unsigned MAXP =
    (FIRST > PERIOD) ? FIRST : PERIOD;
  localparam int unsigned CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] FIRST_C = CW'(FIRST);
  localparam logic [CW-1:0] PER_C   = CW'(PERIOD);

  ar_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q
                                      : cnt_q + CNT_ONE;

  // A press restarts timing and never fires in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (!held) begin
      state_d = AR_IDLE;
      cnt_d   = '0;
    end else if (press) begin
      state_d = AR_DAS;
      cnt_d   = CNT_ONE;
    end else begin
      unique case (state_q)
        AR_IDLE: cnt_d = '0;
        AR_DAS: begin
          if (cnt_q == FIRST_C) begin
            fire    = 1'b1;
            state_d = AR_ARR;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        AR_ARR: begin
          if (cnt_q == PER_C) begin
            fire  = 1'b1;
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = AR_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Keyboard events to Tetris action pulses. Define AUTO_REPEAT_EN
// to add DAS/ARR repeat on left/right and repeat on soft drop.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter int unsigned DAS_CYCLES  = 16_700_000,
  parameter int unsigned ARR_CYCLES  = 5_000_000,
  parameter int unsigned SOFT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] current_scan_code,
  input  logic       current_make_break,
  input  logic       key_event_valid,
  input  logic       enable,
  output logic       move_left,
  output logic       move_right,
  output logic       soft_drop,
  output logic       rotate,
  output logic       hard_drop,
  output logic       hold
);

  logic               valid_q, valid_d;
  logic [NUM_ACT-1:0] held_q, held_d;
  logic [NUM_ACT-1:0] pulse_q, pulse_d;
  dir_e               dir_q, dir_d;

  logic               rise;
  logic [NUM_ACT-1:0] hit;
  logic [NUM_ACT-1:0] makes;
  logic [NUM_ACT-1:0] breaks;
  logic [NUM_ACT-1:0] fresh;

  logic h_press, h_held, h_fire;
  logic d_press, d_held, d_fire;

  assign valid_d = key_event_valid;
  assign rise    = key_event_valid & ~valid_q;
  assign hit     = rise ? key_mask(current_scan_code) : '0;
  assign makes   = hit & {NUM_ACT{current_make_break}};
  assign breaks  = hit & {NUM_ACT{~current_make_break}};
  assign held_d  = (held_q | makes) & ~breaks;
  assign fresh   = makes & ~held_q;

  // Horizontal channel: last pressed direction wins; dropping the
  // active one hands over to the other and restarts its delay.
  always_comb begin
    dir_d   = dir_q;
    h_press = 1'b0;
    unique case (1'b1)
      fresh[ACT_LEFT]: begin
        dir_d   = DIR_LEFT;
        h_press = 1'b1;
      end
      fresh[ACT_RIGHT]: begin
        dir_d   = DIR_RIGHT;
        h_press = 1'b1;
      end
      (dir_q == DIR_LEFT && breaks[ACT_LEFT]
        && held_q[ACT_RIGHT]): begin
        dir_d   = DIR_RIGHT;
        h_press = 1'b1;
      end
      (dir_q == DIR_RIGHT && breaks[ACT_RIGHT]
        && held_q[ACT_LEFT]): begin
        dir_d   = DIR_LEFT;
        h_press = 1'b1;
      end
      default: ;
    endcase
  end

  assign h_held = enable & ((dir_d == DIR_LEFT)
                  ? held_d[ACT_LEFT] : held_d[ACT_RIGHT]);
  assign d_held = enable & held_d[ACT_DOWN];
  assign d_press = enable & fresh[ACT_DOWN];

`ifdef AUTO_REPEAT_EN
  auto_repeat #(
    .FIRST (DAS_CYCLES),
    .PERIOD(ARR_CYCLES)
  ) u_horiz (
    .clk  (clk),
    .rst  (rst),
    .press(enable & h_press),
    .held (h_held),
    .fire (h_fire)
  );

  auto_repeat #(
    .FIRST (SOFT_CYCLES),
    .PERIOD(SOFT_CYCLES)
  ) u_soft (
    .clk  (clk),
    .rst  (rst),
    .press(d_press),
    .held (d_held),
    .fire (d_fire)
  );
`else
  localparam int unsigned unused_cfg =
    DAS_CYCLES ^ ARR_CYCLES ^ SOFT_CYCLES;
  logic unused_sig;
  assign unused_sig = ^{h_press, h_held, d_press, d_held,
                        unused_cfg[0]};
  assign h_fire = 1'b0;
  assign d_fire = 1'b0;
`endif

  always_comb begin
    pulse_d = '0;
    if (enable) begin
      pulse_d[ACT_LEFT]  = fresh[ACT_LEFT]
                         | (h_fire & (dir_d == DIR_LEFT));
      pulse_d[ACT_RIGHT] = fresh[ACT_RIGHT]
                         | (h_fire & (dir_d == DIR_RIGHT));
      pulse_d[ACT_DOWN]  = fresh[ACT_DOWN] | d_fire;
      pulse_d[ACT_ROT]   = fresh[ACT_ROT];
      pulse_d[ACT_DROP]  = fresh[ACT_DROP];
      pulse_d[ACT_HOLD]  = fresh[ACT_HOLD];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      held_q  <= '0;
      pulse_q <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      valid_q <= valid_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
    end
  end

  assign move_left  = pulse_q[ACT_LEFT];
  assign move_right = pulse_q[ACT_RIGHT];
  assign soft_drop  = pulse_q[ACT_DOWN];
  assign rotate     = pulse_q[ACT_ROT];
  assign hard_drop  = pulse_q[ACT_DROP];
  assign hold       = pulse_q[ACT_HOLD];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed vector table plus multi-cycle sequences for
// tetris_input_ctrl (repeat expectations follow AUTO_REPEAT_EN).
module tb_tetris_input_ctrl;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam logic [5:0] XL = 6'b100000;
  localparam logic [5:0] XR = 6'b010000;
  localparam logic [5:0] XD = 6'b001000;
  localparam logic [5:0] XU = 6'b000100;
  localparam logic [5:0] XS = 6'b000010;
  localparam logic [5:0] XH = 6'b000001;
  localparam logic [5:0] X0 = 6'b000000;

  logic       clk = 1'b0;
  logic       rst, en, vld, mb;
  logic [7:0] code;
  logic       move_left, move_right, soft_drop;
  logic       rotate, hard_drop, hold;
  logic [5:0] obs;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic       r;
    logic       e;
    logic       v;
    logic [7:0] c;
    logic       m;
    logic [5:0] x;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  assign obs = {move_left, move_right, soft_drop,
                rotate, hard_drop, hold};

  tetris_input_ctrl #(
    .DAS_CYCLES (20),
    .ARR_CYCLES (5),
    .SOFT_CYCLES(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .current_scan_code (code),
    .current_make_break(mb),
    .key_event_valid   (vld),
    .enable            (en),
    .move_left         (move_left),
    .move_right        (move_right),
    .soft_drop         (soft_drop),
    .rotate            (rotate),
    .hard_drop         (hard_drop),
    .hold              (hold)
  );

  task automatic drive(input logic r, input logic e,
                       input logic v, input logic [7:0] c,
                       input logic m);
    rst  = r;
    en   = e;
    vld  = v;
    code = c;
    mb   = m;
  endtask

  task automatic check(input string nm, input int i,
                       input logic [5:0] x);
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== x) begin
      errors++;
      $display("FAIL %s[%0d]: got %b want %b", nm, i, obs, x);
    end
  endtask

  task automatic add(input logic r, input logic e,
                     input logic v, input logic [7:0] c,
                     input logic m, input logic [5:0] x);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.c = c; t.m = m; t.x = x;
    tbl.push_back(t);
  endtask

  initial begin
    logic [5:0] x;
    drive(1, 1, 0, 8'h00, 0);

    // reset, hard drop with 4-cycle strobe
    add(1, 1, 0, 8'h00, 0, X0);
    add(1, 1, 0, 8'h00, 0, X0);
    add(0, 1, 0, 8'h00, 0, X0);
    add(0, 1, 1, 8'h29, 1, XS);
    add(0, 1, 1, 8'h29, 1, X0);
    add(0, 1, 1, 8'h29, 1, X0);
    add(0, 1, 1, 8'h29, 1, X0);
    add(0, 1, 0, 8'h29, 1, X0);
    add(0, 1, 1, 8'h29, 0, X0);
    add(0, 1, 0, 8'h29, 0, X0);
    // rotate: press, typematic twice, break
    add(0, 1, 1, 8'h75, 1, XU);
    add(0, 1, 0, 8'h75, 1, X0);
    add(0, 1, 1, 8'h75, 1, X0);
    add(0, 1, 0, 8'h75, 1, X0);
    add(0, 1, 1, 8'h75, 1, X0);
    add(0, 1, 0, 8'h75, 1, X0);
    add(0, 1, 1, 8'h75, 0, X0);
    add(0, 1, 0, 8'h75, 0, X0);
    // hold, left, right, down taps
    add(0, 1, 1, 8'h12, 1, XH);
    add(0, 1, 0, 8'h12, 1, X0);
    add(0, 1, 1, 8'h12, 0, X0);
    add(0, 1, 0, 8'h12, 0, X0);
    add(0, 1, 1, 8'h6B, 1, XL);
    add(0, 1, 0, 8'h6B, 1, X0);
    add(0, 1, 1, 8'h6B, 0, X0);
    add(0, 1, 0, 8'h6B, 0, X0);
    add(0, 1, 1, 8'h74, 1, XR);
    add(0, 1, 0, 8'h74, 1, X0);
    add(0, 1, 1, 8'h74, 0, X0);
    add(0, 1, 0, 8'h74, 0, X0);
    add(0, 1, 1, 8'h72, 1, XD);
    add(0, 1, 0, 8'h72, 1, X0);
    add(0, 1, 1, 8'h72, 0, X0);
    add(0, 1, 0, 8'h72, 0, X0);
    // unmapped code; code change under a still-high strobe
    add(0, 1, 1, 8'h1C, 1, X0);
    add(0, 1, 0, 8'h1C, 1, X0);
    add(0, 1, 1, 8'h1C, 0, X0);
    add(0, 1, 1, 8'h6B, 1, X0);
    add(0, 1, 0, 8'h6B, 1, X0);
    add(0, 1, 1, 8'h6B, 1, XL);
    add(0, 1, 0, 8'h6B, 1, X0);
    add(0, 1, 1, 8'h6B, 0, X0);
    add(0, 1, 0, 8'h6B, 0, X0);
    // make while disabled: held but silent until re-pressed
    add(0, 0, 1, 8'h75, 1, X0);
    add(0, 1, 0, 8'h75, 1, X0);
    add(0, 1, 1, 8'h75, 1, X0);
    add(0, 1, 0, 8'h75, 1, X0);
    add(0, 1, 1, 8'h75, 0, X0);
    add(0, 1, 0, 8'h75, 0, X0);
    add(0, 1, 1, 8'h75, 1, XU);
    add(0, 1, 0, 8'h75, 1, X0);
    add(0, 1, 1, 8'h75, 0, X0);
    add(0, 1, 0, 8'h75, 0, X0);

    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].e, tbl[k].v, tbl[k].c, tbl[k].m);
      check("table", k, tbl[k].x);
    end

    // left held 40 cycles: press, DAS, ARR, stop on break
    for (int i = 0; i < 52; i++) begin
      drive(0, 1, (i == 0 || i == 40), 8'h6B, (i == 0));
      x = X0;
      if (i == 0 || (AR && (i == 20 || i == 25 ||
                            i == 30 || i == 35)))
        x = XL;
      check("das_hold", i, x);
    end

    // left, right over it, release right, release left
    for (int i = 0; i < 72; i++) begin
      drive(0, 1,
            (i == 0 || i == 10 || i == 30 || i == 62),
            (i == 10 || i == 30) ? 8'h74 : 8'h6B,
            (i == 0 || i == 10));
      x = X0;
      if (i == 0 || (AR && (i == 50 || i == 55 || i == 60)))
        x = XL;
      if (i == 10)
        x = XR;
      check("lr_swap", i, x);
    end

    // soft drop pressed while disabled, then re-pressed
    for (int i = 0; i < 60; i++) begin
      drive(0, (i >= 3),
            (i == 0 || i == 10 || i == 22 || i == 24 || i == 50),
            8'h72, (i == 0 || i == 10 || i == 24));
      x = X0;
      if (i == 24 || (AR && (i == 32 || i == 40 || i == 48)))
        x = XD;
      check("soft_en", i, x);
    end

    // reset in the middle of a left repeat
    for (int i = 0; i < 70; i++) begin
      drive((i == 30), 1,
            (i == 0 || i == 50 || i == 55 || i == 58),
            8'h6B, (i == 0 || i == 55));
      x = X0;
      if (i == 0 || i == 55 || (AR && (i == 20 || i == 25)))
        x = XL;
      check("rst_mid", i, x);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/tetris_input_ctrl.md
TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 Parameter DAS_CYCLES, default 16_700_000: delay from press pulse to first auto-repeat (167 ms at 100 MHz).
REQ-002 Parameter ARR_CYCLES, default 5_000_000: auto-repeat period for left/right.
REQ-003 Parameter SOFT_CYCLES, default 5_000_000: repeat period for soft drop.
REQ-004 One clock and one reset: reset is synchronous and active-high.
REQ-005 clk  in  1  system clock, 100 MHz.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 current_scan_code  in  8  scan code latched by ps2_keyboard.
REQ-008 current_make_break  in  1  1=make, 0=break.
REQ-009 key_event_valid  in  1  event strobe; may stay high for several cycles per event.
REQ-010 enable  in  1  game active; 0 forces all action outputs low.
REQ-011 move_left, move_right, soft_drop, rotate, hard_drop, hold  out  1 each  single-cycle action pulses.

Function
REQ-012 Event detection SHALL use the rising edge of key_event_valid only; each event is processed exactly once, whatever the strobe length.
REQ-013 Key map SHALL be: 0x6B left, 0x74 right, 0x72 down, 0x75 rotate, 0x29 hard_drop, 0x12 hold; all other codes are ignored.
REQ-014 Each mapped key SHALL have a held flag: set on make, cleared on break.
REQ-015 A make for a key whose held flag is already set (typematic repeat) SHALL produce no pulse.
REQ-016 A make for a non-held key SHALL pulse its action for one cycle, on the cycle after the first cycle key_event_valid is high (latency 1).
REQ-017 Rotate, hard_drop and hold SHALL pulse only on press and never repeat.
REQ-018 Left/right SHALL act as a single horizontal channel: the last pressed direction is active.
REQ-019 Releasing the active direction while the other is held SHALL make the other active and restart its DAS with no immediate pulse.
REQ-020 Releasing a non-active direction SHALL leave the active channel's timing unchanged.
REQ-021 Soft drop SHALL run independently of the horizontal channel.
REQ-022 Counters SHALL be sized as $clog2(max parameter)+1 and saturate; they never wrap.
REQ-023 With enable=0, held flags SHALL still update, outputs SHALL be 0, and repeat counters SHALL hold at 0.
REQ-024 On enable rising, no pulses SHALL occur until a fresh make.
REQ-025 At most one horizontal pulse SHALL be asserted per cycle; move_left and move_right are never high together.

Reset
REQ-026 On rst, all outputs, held flags, edge register, active direction and counters SHALL clear to 0.
REQ-027 Reset during a held key SHALL cancel repeat; the key must be re-pressed to act.

Configuration
REQ-028 With AUTO_REPEAT_EN defined, left/right SHALL repeat at press+1+DAS_CYCLES, then every ARR_CYCLES while held.
REQ-029 With AUTO_REPEAT_EN defined, soft_drop SHALL repeat every SOFT_CYCLES after its press pulse while held.
REQ-030 Without AUTO_REPEAT_EN, only press pulses SHALL occur: repeat counters are absent and the parameters are unused.

Structure
REQ-031 Package tetris_input_pkg SHALL hold the scan-code localparams (KEY_LEFT=8'h6B, KEY_RIGHT=8'h74, KEY_DOWN=8'h72, KEY_UP=8'h75, KEY_SPACE=8'h29, KEY_LSHIFT=8'h12) and the action_e enum.
REQ-032 Sub-module auto_repeat SHALL provide (press, held) -> repeat-pulse timing with parameters FIRST and PERIOD.
REQ-033 auto_repeat SHALL be instantiated twice: horizontal channel (DAS/ARR) and soft drop (SOFT/SOFT).

Verification
REQ-034 Bench SHALL use DAS_CYCLES=20, ARR_CYCLES=5, SOFT_CYCLES=8 with AUTO_REPEAT_EN defined.
REQ-035 Make 0x29 with a 4-cycle strobe -> exactly one hard_drop pulse, 1 cycle after strobe rise.
REQ-036 Make 0x6B at T0, held for 40 cycles -> move_left at T0+1, T0+21, T0+26, T0+31, T0+36; none after the break.
REQ-037 Make 0x6B, then make 0x74 at +10, break 0x74 at +30 -> move_right at +11; move_left resumes at +30+1+20; no overlap.
REQ-038 Make 0x75 three times without break -> one rotate pulse; break, then make -> second pulse.
REQ-039 enable=0 during make 0x72, then enable=1 while held -> no soft_drop pulses; re-press -> pulse and repeat every 8 cycles.
REQ-040 rst asserted mid-repeat of left -> all outputs 0 next cycle; no further move_left until a new make.
